// File: rtl/rv_pkg.sv
// Shared decode definitions: opcodes, ALU op codes, occupancy states and the
// decoded bundle (sized for XLEN up to 64 and truncated at the ports).
package rv_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic        op2;
    logic        y;
    logic        rwrite;
    logic        mwrite;
    logic        load;
    logic        rsel;
    logic        branch;
    logic        jump;
    logic        muldiv;
    logic        illegal;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } bundle_t;

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake plus the decoded bundle outputs.
interface decode_if #(
  parameter int XLEN = 32
);

  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_inst;
  logic [XLEN-1:0] i_pc;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [2:0]      o_op;
  logic            o_op2;
  logic            o_y;
  logic            o_rwrite;
  logic            o_mwrite;
  logic            o_load;
  logic            o_rsel;
  logic            o_branch;
  logic            o_jump;
  logic            o_muldiv;
  logic            o_illegal;
  logic [XLEN-1:0] o_imm;
  logic [XLEN-1:0] o_pc;
  logic [4:0]      o_rd;
  logic [4:0]      o_rs1;
  logic [4:0]      o_rs2;

  modport master (
    output i_valid, i_inst, i_pc, i_flush, i_ready,
    input  o_ready, o_valid, o_op, o_op2, o_y, o_rwrite, o_mwrite, o_load,
           o_rsel, o_branch, o_jump, o_muldiv, o_illegal, o_imm, o_pc,
           o_rd, o_rs1, o_rs2
  );

  modport slave (
    input  i_valid, i_inst, i_pc, i_flush, i_ready,
    output o_ready, o_valid, o_op, o_op2, o_y, o_rwrite, o_mwrite, o_load,
           o_rsel, o_branch, o_jump, o_muldiv, o_illegal, o_imm, o_pc,
           o_rd, o_rs1, o_rs2
  );

endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32/RV64 instruction decoder producing one bundle.
module decode_comb
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output bundle_t         dec
);

  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal;

  assign opcode = inst[6:2];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    dec             = '0;
    illegal         = 1'b0;
    dec.pc[XLEN-1:0] = pc;
    dec.rd          = inst[11:7];
    dec.rs1         = inst[19:15];
    dec.rs2         = inst[24:20];

    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec.y      = 1'b1;
        dec.rwrite = 1'b1;
        dec.imm    = {{32{inst[31]}}, inst[31:12], 12'b0};
      end
      // Branch and jump offsets are halfword-granular, hence the implied zero LSB.
      OPC_JAL: begin
        dec.y      = 1'b1;
        dec.rwrite = 1'b1;
        dec.jump   = 1'b1;
        dec.imm    = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec.y      = 1'b1;
        dec.rwrite = 1'b1;
        dec.jump   = 1'b1;
        dec.imm    = {{52{inst[31]}}, inst[31:20]};
      end
      OPC_LOAD: begin
        dec.y      = 1'b1;
        dec.rwrite = 1'b1;
        dec.load   = 1'b1;
        dec.rsel   = 1'b1;
        dec.imm    = {{52{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        dec.y      = 1'b1;
        dec.mwrite = 1'b1;
        dec.imm    = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_OP_IMM: begin
        dec.y      = 1'b1;
        dec.rwrite = 1'b1;
        dec.op     = funct3;
        dec.op2    = inst[30] && (funct3 == 3'b101);
        if (funct3 == 3'b011)
          dec.imm = {52'b0, inst[31:20]};
        else if (funct3 == 3'b001 || funct3 == 3'b101)
          dec.imm = (XLEN == 64) ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
        else
          dec.imm = {{52{inst[31]}}, inst[31:20]};
      end
      OPC_OP: begin
        dec.rwrite = 1'b1;
        dec.op     = funct3;
        if (funct7 == 7'b0000001) begin
          dec.muldiv = EN_M;
          illegal    = !EN_M;
        end else begin
          dec.op2 = inst[30];
        end
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.imm    = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        case (funct3)
          3'b000, 3'b001: begin
            dec.op  = ALU_ADD;
            dec.op2 = 1'b1;
          end
          3'b100, 3'b101: dec.op = ALU_SLT;
          3'b110, 3'b111: dec.op = ALU_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      OPC_MISC_MEM: ;
      default: illegal = 1'b1;
    endcase

    if (inst[1:0] != 2'b11)
      illegal = 1'b1;

    if (illegal) begin
      dec.rwrite = 1'b0;
      dec.mwrite = 1'b0;
      dec.load   = 1'b0;
      dec.rsel   = 1'b0;
      dec.branch = 1'b0;
      dec.jump   = 1'b0;
      dec.muldiv = 1'b0;
    end

    if (dec.rd == 5'd0)
      dec.rwrite = 1'b0;

    dec.illegal = illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: combinational decode feeding a 2-entry skid FIFO
// behind a valid/ready handshake, with flush and synchronous active-low reset.
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  decode_if.slave bus
);

  bundle_t    dec;
  bundle_t    head;
  bundle_t    tail;
  occ_state_t state;
  logic       valid_q;
  logic       ready_q;
  logic       accept;
  logic       pop;

  decode_comb #(.XLEN(XLEN), .EN_M(EN_M)) u_decode (
    .inst (bus.i_inst),
    .pc   (bus.i_pc),
    .dec  (dec)
  );

  assign accept = bus.i_valid && ready_q;
  assign pop    = valid_q && bus.i_ready;

  // Head is always the oldest entry; tail only holds the second one while FULL.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_EMPTY;
      head    <= '0;
      tail    <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (bus.i_flush) begin
      state   <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            head    <= dec;
            state   <= ST_ONE;
            valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head <= dec;
          end else if (accept) begin
            tail    <= dec;
            state   <= ST_FULL;
            ready_q <= 1'b0;
          end else if (pop) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head    <= tail;
            state   <= ST_ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_op      = head.op;
  assign bus.o_op2     = head.op2;
  assign bus.o_y       = head.y;
  assign bus.o_rwrite  = head.rwrite;
  assign bus.o_mwrite  = head.mwrite;
  assign bus.o_load    = head.load;
  assign bus.o_rsel    = head.rsel;
  assign bus.o_branch  = head.branch;
  assign bus.o_jump    = head.jump;
  assign bus.o_muldiv  = head.muldiv;
  assign bus.o_illegal = head.illegal;
  assign bus.o_imm     = head.imm[XLEN-1:0];
  assign bus.o_pc      = head.pc[XLEN-1:0];
  assign bus.o_rd      = head.rd;
  assign bus.o_rs1     = head.rs1;
  assign bus.o_rs2     = head.rs2;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: one EN_M=1 and one EN_M=0
// instance driven with identical stimulus.
module tb_decode_stage;

  logic clk;
  logic rst_n;
  int   pass_count;
  int   check_count;

  decode_if #(.XLEN(32)) bus ();
  decode_if #(.XLEN(32)) bus_nm ();

  decode_stage #(.XLEN(32), .EN_M(1'b1)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  decode_stage #(.XLEN(32), .EN_M(1'b0)) dut_nm (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_nm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                               input logic [31:0] pc, input logic ready,
                               input logic flush);
    bus.i_valid    = valid;
    bus.i_inst     = inst;
    bus.i_pc       = pc;
    bus.i_ready    = ready;
    bus.i_flush    = flush;
    bus_nm.i_valid = valid;
    bus_nm.i_inst  = inst;
    bus_nm.i_pc    = pc;
    bus_nm.i_ready = ready;
    bus_nm.i_flush = flush;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;

    // Reset held two cycles with a valid instruction presented
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'hFFF00093, 32'h0000_0100, 1'b1, 1'b0);
    step();
    step();
    checkOutput("reset_valid",  bus.o_valid,  1'b0);
    checkOutput("reset_ready",  bus.o_ready,  1'b1);
    checkOutput("reset_imm",    bus.o_imm,    32'h0);
    checkOutput("reset_pc",     bus.o_pc,     32'h0);
    checkOutput("reset_rwrite", bus.o_rwrite, 1'b0);

    // Back-to-back ADDI x1,x0,-1 then SUB x3,x1,x2
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'hFFF00093, 32'h0000_0100, 1'b1, 1'b0);
    step();
    checkOutput("addi_valid",  bus.o_valid,  1'b1);
    checkOutput("addi_op",     bus.o_op,     3'b000);
    checkOutput("addi_y",      bus.o_y,      1'b1);
    checkOutput("addi_imm",    bus.o_imm,    32'hFFFF_FFFF);
    checkOutput("addi_rwrite", bus.o_rwrite, 1'b1);
    checkOutput("addi_rd",     bus.o_rd,     5'd1);
    checkOutput("addi_pc",     bus.o_pc,     32'h0000_0100);
    applyStimulus(1'b1, 32'h402081B3, 32'h0000_0104, 1'b1, 1'b0);
    step();
    checkOutput("sub_valid",  bus.o_valid,  1'b1);
    checkOutput("sub_op2",    bus.o_op2,    1'b1);
    checkOutput("sub_y",      bus.o_y,      1'b0);
    checkOutput("sub_rwrite", bus.o_rwrite, 1'b1);
    checkOutput("sub_rd",     bus.o_rd,     5'd3);
    checkOutput("sub_rs1",    bus.o_rs1,    5'd1);
    checkOutput("sub_rs2",    bus.o_rs2,    5'd2);
    checkOutput("sub_pc",     bus.o_pc,     32'h0000_0104);

    // BLTU x1,x2,+8
    applyStimulus(1'b1, 32'h0020E463, 32'h0000_0108, 1'b1, 1'b0);
    step();
    checkOutput("bltu_branch", bus.o_branch, 1'b1);
    checkOutput("bltu_op",     bus.o_op,     3'b011);
    checkOutput("bltu_op2",    bus.o_op2,    1'b0);
    checkOutput("bltu_imm",    bus.o_imm,    32'h8);
    checkOutput("bltu_rwrite", bus.o_rwrite, 1'b0);

    // ADDI x0,x0,0: write to x0 suppressed
    applyStimulus(1'b1, 32'h00000013, 32'h0000_010C, 1'b1, 1'b0);
    step();
    checkOutput("nop_rwrite",  bus.o_rwrite,  1'b0);
    checkOutput("nop_illegal", bus.o_illegal, 1'b0);

    // MUL x1,x2,x3 on both M-enabled and M-disabled instances
    applyStimulus(1'b1, 32'h023100B3, 32'h0000_0110, 1'b1, 1'b0);
    step();
    checkOutput("mul_muldiv",     bus.o_muldiv,     1'b1);
    checkOutput("mul_op",         bus.o_op,         3'b000);
    checkOutput("mul_rwrite",     bus.o_rwrite,     1'b1);
    checkOutput("mul_illegal",    bus.o_illegal,    1'b0);
    checkOutput("mulnm_illegal",  bus_nm.o_illegal, 1'b1);
    checkOutput("mulnm_rwrite",   bus_nm.o_rwrite,  1'b0);
    checkOutput("mulnm_muldiv",   bus_nm.o_muldiv,  1'b0);

    applyStimulus(1'b0, 32'h00000013, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("drain_valid", bus.o_valid, 1'b0);

    // Backpressure: three instructions with execute stalled
    applyStimulus(1'b1, 32'h00100293, 32'h0000_0200, 1'b0, 1'b0);
    step();
    checkOutput("bp1_ready", bus.o_ready, 1'b1);
    checkOutput("bp1_valid", bus.o_valid, 1'b1);
    applyStimulus(1'b1, 32'h00200313, 32'h0000_0204, 1'b0, 1'b0);
    step();
    checkOutput("bp2_ready", bus.o_ready, 1'b0);
    applyStimulus(1'b1, 32'h00300393, 32'h0000_0208, 1'b0, 1'b0);
    step();
    checkOutput("bp3_ready",   bus.o_ready, 1'b0);
    checkOutput("bp3_hold_pc", bus.o_pc,    32'h0000_0200);
    checkOutput("bp3_hold_rd", bus.o_rd,    5'd5);
    applyStimulus(1'b1, 32'h00300393, 32'h0000_0208, 1'b1, 1'b0);
    step();
    checkOutput("rel1_pc",    bus.o_pc,    32'h0000_0204);
    checkOutput("rel1_imm",   bus.o_imm,   32'h2);
    checkOutput("rel1_ready", bus.o_ready, 1'b1);
    step();
    checkOutput("rel2_pc",  bus.o_pc,  32'h0000_0208);
    checkOutput("rel2_rd",  bus.o_rd,  5'd7);
    applyStimulus(1'b0, 32'h00000013, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("rel3_valid", bus.o_valid, 1'b0);

    // Flush while FULL with a simultaneous incoming instruction
    applyStimulus(1'b1, 32'h00100293, 32'h0000_0300, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h00200313, 32'h0000_0304, 1'b0, 1'b0);
    step();
    checkOutput("prefl_ready", bus.o_ready, 1'b0);
    applyStimulus(1'b1, 32'h00300393, 32'h0000_0308, 1'b0, 1'b1);
    step();
    checkOutput("flush_valid", bus.o_valid, 1'b0);
    checkOutput("flush_ready", bus.o_ready, 1'b1);
    applyStimulus(1'b0, 32'h00000013, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("postfl_valid", bus.o_valid, 1'b0);
    applyStimulus(1'b1, 32'h00400413, 32'h0000_0400, 1'b1, 1'b0);
    step();
    checkOutput("postfl_pc",  bus.o_pc,  32'h0000_0400);
    checkOutput("postfl_rd",  bus.o_rd,  5'd8);
    checkOutput("postfl_imm", bus.o_imm, 32'h4);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
